// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
//   lsu_state_t : FSM state encoding (IDLE, BUS, RESP)
//   SZ_*        : ldsz access-size encodings (2'b10 is handled as a word)
//   CNT_W       : width of the bus wait counter (covers TIMEOUT up to 255)
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b11;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
// Inputs : ldsz, ldshift, st_data, rdata, ld_unsigned
// Outputs: be (byte enables), wdata (replicated store data),
//          ld_data (extracted, sign/zero-extended load data)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  ldsz,
    input  logic [1:0]  ldshift,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    input  logic        ld_unsigned,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Size decode; anything that is not byte or half behaves as a word.
    always_comb begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = rdata;
        w_byte  = 8'(rdata >> {ldshift, 3'b000});
        w_half  = 16'(rdata >> {ldshift[1], 4'b0000});
        case (ldsz)
            SZ_B: begin
                be      = 4'b0001 << ldshift;
                wdata   = {4{st_data[7:0]}};
                ld_data = ld_unsigned ? {24'd0, w_byte}
                                      : {{24{w_byte[7]}}, w_byte};
            end
            SZ_H: begin
                be      = 4'b0011 << {ldshift[1], 1'b0};
                wdata   = {2{st_data[15:0]}};
                ld_data = ld_unsigned ? {16'd0, w_half}
                                      : {{16{w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs one data-memory transaction per
// request over a valid/ack bus and returns formatted load data.
// Inputs : clk, reset_n (sync, active-low), req_valid, is_store, ldsz,
//          ld_unsigned, addr, ldshift, st_data, rd, dmem_ack, dmem_rdata
// Outputs: busy (decoded from state), done, rd_out, res_out, mem_err,
//          dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata (registered)
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        is_store,
    input  logic [1:0]  ldsz,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [1:0]  ldshift,
    input  logic [31:0] st_data,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_out,
    output logic [31:0] res_out,
    output logic        mem_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    lsu_state_t       r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_capture, w_timeout;

    logic             r_is_store, r_uns;
    logic [1:0]       r_ldsz, r_ldshift;
    logic [4:0]       r_rd;

    logic             r_done, r_mem_err, r_dmem_req, r_dmem_we;
    logic [4:0]       r_rd_out;
    logic [31:0]      r_res_out, r_dmem_addr, r_dmem_wdata;
    logic [3:0]       r_dmem_be;

    logic [1:0]       w_sel_ldsz, w_sel_shift;
    logic             w_sel_uns;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata, w_ld_data;

    // One aligner serves both phases: request fields while accepting,
    // captured fields while waiting for read data.
    assign w_sel_ldsz  = (r_state == BUS) ? r_ldsz    : ldsz;
    assign w_sel_shift = (r_state == BUS) ? r_ldshift : ldshift;
    assign w_sel_uns   = (r_state == BUS) ? r_uns     : ld_unsigned;

    lsu_align u_align (
        .ldsz        (w_sel_ldsz),
        .ldshift     (w_sel_shift),
        .st_data     (st_data),
        .rdata       (dmem_rdata),
        .ld_unsigned (w_sel_uns),
        .be          (w_be),
        .wdata       (w_wdata),
        .ld_data     (w_ld_data)
    );

    // State and wait-counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; an ack on the limit cycle takes priority.
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE, RESP: begin
                if (req_valid) begin
                    w_next    = BUS;
                    w_capture = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_next = IDLE;
                end
            end
            BUS: begin
                if (dmem_ack) begin
                    w_next = RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_is_store   <= 1'b0;
            r_uns        <= 1'b0;
            r_ldsz       <= 2'd0;
            r_ldshift    <= 2'd0;
            r_rd         <= 5'd0;
            r_done       <= 1'b0;
            r_mem_err    <= 1'b0;
            r_rd_out     <= 5'd0;
            r_res_out    <= 32'd0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_be    <= 4'd0;
            r_dmem_addr  <= 32'd0;
            r_dmem_wdata <= 32'd0;
        end else begin
            r_done     <= (w_next == RESP);
            r_mem_err  <= w_timeout;
            r_dmem_req <= (w_next == BUS);
            if (w_next == RESP) begin
                r_rd_out  <= r_is_store ? 5'd0  : r_rd;
                r_res_out <= r_is_store ? 32'd0 : w_ld_data;
            end else begin
                r_rd_out  <= 5'd0;
                r_res_out <= 32'd0;
            end
            if (w_capture) begin
                r_is_store   <= is_store;
                r_uns        <= ld_unsigned;
                r_ldsz       <= ldsz;
                r_ldshift    <= ldshift;
                r_rd         <= rd;
                r_dmem_we    <= is_store;
                r_dmem_be    <= w_be;
                r_dmem_addr  <= addr;
                r_dmem_wdata <= w_wdata;
            end else if (w_next != BUS) begin
                r_dmem_we    <= 1'b0;
                r_dmem_be    <= 4'd0;
                r_dmem_addr  <= 32'd0;
                r_dmem_wdata <= 32'd0;
            end
        end
    end

    assign busy       = (r_state == BUS);
    assign done       = r_done;
    assign rd_out     = r_rd_out;
    assign res_out    = r_res_out;
    assign mem_err    = r_mem_err;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_be    = r_dmem_be;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu (TIMEOUT = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, is_store, ld_unsigned, dmem_ack;
    logic [1:0]  ldsz, ldshift;
    logic [31:0] addr, st_data, dmem_rdata;
    logic [4:0]  rd;
    logic        busy, done, mem_err, dmem_req, dmem_we;
    logic [4:0]  rd_out;
    logic [31:0] res_out, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .is_store(is_store),
        .ldsz(ldsz), .ld_unsigned(ld_unsigned), .addr(addr), .ldshift(ldshift),
        .st_data(st_data), .rd(rd), .busy(busy), .done(done), .rd_out(rd_out),
        .res_out(res_out), .mem_err(mem_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    // Present one request for a single cycle; returns in the first BUS cycle.
    task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [1:0] sh,
                         input logic [31:0] sd, input logic [4:0] r);
        req_valid = 1'b1; is_store = st; ldsz = sz; ld_unsigned = uns;
        addr = a; ldshift = sh; st_data = sd; rd = r;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, mem_err, dmem_req, dmem_we} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl actual=%b required=00000", {busy, done, mem_err, dmem_req, dmem_we});
        end
        checks++;
        if ({rd_out, res_out, dmem_be, dmem_addr, dmem_wdata} !== 105'd0) begin
            failures++; $display("FAIL reset_data rd_out=%h res_out=%h be=%h addr=%h wdata=%h required=0",
                                 rd_out, res_out, dmem_be, dmem_addr, dmem_wdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
        // Ack while idle must be ignored.
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({done, busy, dmem_req} !== 3'b000) begin
            failures++; $display("FAIL idle_ack done/busy/req actual=%b required=000", {done, busy, dmem_req});
        end
    endtask

    task automatic test_lw();
        issue(1'b0, 2'b11, 1'b0, 32'h100, 2'd0, 32'd0, 5'd5);
        checks++;
        if ({dmem_req, busy, dmem_we} !== 3'b110) begin
            failures++; $display("FAIL lw_req req/busy/we actual=%b required=110", {dmem_req, busy, dmem_we});
        end
        checks++;
        if (dmem_be !== 4'b1111) begin
            failures++; $display("FAIL lw_be actual=%b required=1111", dmem_be);
        end
        checks++;
        if (dmem_addr !== 32'h100) begin
            failures++; $display("FAIL lw_addr actual=%h required=00000100", dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({done, busy, dmem_req} !== 3'b100) begin
            failures++; $display("FAIL lw_done done/busy/req actual=%b required=100", {done, busy, dmem_req});
        end
        checks++;
        if (rd_out !== 5'd5) begin
            failures++; $display("FAIL lw_rd actual=%0d required=5", rd_out);
        end
        checks++;
        if (res_out !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL lw_res actual=%h required=deadbeef", res_out);
        end
        @(negedge clk);
        checks++;
        if ({done, rd_out, res_out} !== 38'd0) begin
            failures++; $display("FAIL lw_pulse done=%b rd_out=%0d res_out=%h required=0", done, rd_out, res_out);
        end
    endtask

    task automatic test_lb();
        issue(1'b0, 2'b00, 1'b0, 32'h200, 2'd3, 32'd0, 5'd7);
        checks++;
        if (dmem_be !== 4'b1000) begin
            failures++; $display("FAIL lb_be actual=%b required=1000", dmem_be);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h8012_3456;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if (res_out !== 32'hFFFF_FF80 || rd_out !== 5'd7 || done !== 1'b1) begin
            failures++; $display("FAIL lb_res res=%h rd=%0d done=%b required=ffffff80/7/1", res_out, rd_out, done);
        end
        // Same access zero-extended, issued straight out of RESP.
        issue(1'b0, 2'b00, 1'b1, 32'h200, 2'd3, 32'd0, 5'd7);
        dmem_ack = 1'b1; dmem_rdata = 32'h8012_3456;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if (res_out !== 32'h0000_0080 || done !== 1'b1) begin
            failures++; $display("FAIL lbu_res res=%h done=%b required=00000080/1", res_out, done);
        end
        @(negedge clk);
    endtask

    task automatic test_sh();
        issue(1'b1, 2'b01, 1'b0, 32'h300, 2'd2, 32'h0000_ABCD, 5'd9);
        checks++;
        if (dmem_we !== 1'b1 || dmem_be !== 4'b1100) begin
            failures++; $display("FAIL sh_we_be we=%b be=%b required=1/1100", dmem_we, dmem_be);
        end
        checks++;
        if (dmem_wdata !== 32'hABCD_ABCD) begin
            failures++; $display("FAIL sh_wdata actual=%h required=abcdabcd", dmem_wdata);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || rd_out !== 5'd0 || res_out !== 32'd0) begin
            failures++; $display("FAIL sh_done done=%b rd=%0d res=%h required=1/0/0", done, rd_out, res_out);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        issue(1'b0, 2'b11, 1'b0, 32'h400, 2'd0, 32'd0, 5'd11);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({dmem_req, busy, mem_err, done} !== 4'b1100) begin
                failures++; $display("FAIL to_req cycle=%0d req/busy/err/done actual=%b required=1100",
                                     i, {dmem_req, busy, mem_err, done});
            end
            @(negedge clk);
        end
        checks++;
        if ({dmem_req, busy, mem_err, done} !== 4'b0010) begin
            failures++; $display("FAIL to_err req/busy/err/done actual=%b required=0010", {dmem_req, busy, mem_err, done});
        end
        checks++;
        if (rd_out !== 5'd0) begin
            failures++; $display("FAIL to_rd actual=%0d required=0", rd_out);
        end
        @(negedge clk);
        checks++;
        if ({mem_err, done} !== 2'b00) begin
            failures++; $display("FAIL to_pulse err/done actual=%b required=00", {mem_err, done});
        end
    endtask

    task automatic test_ack_at_limit();
        issue(1'b0, 2'b11, 1'b0, 32'h500, 2'd0, 32'd0, 5'd12);
        repeat (3) @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({done, mem_err} !== 2'b10 || res_out !== 32'h0BAD_F00D || rd_out !== 5'd12) begin
            failures++; $display("FAIL limit_ack done/err=%b res=%h rd=%0d required=10/0badf00d/12",
                                 {done, mem_err}, res_out, rd_out);
        end
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b0) begin
            failures++; $display("FAIL limit_err actual=%b required=0", mem_err);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 2'b11, 1'b0, 32'h600, 2'd0, 32'd0, 5'd3);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++; $display("FAIL b2b_busy1 cycle=%0d actual=%b required=1", k, busy);
            end
            if (k == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222; end
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || rd_out !== 5'd3 || res_out !== 32'h1111_2222 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_first done=%b rd=%0d res=%h busy=%b required=1/3/11112222/0",
                                 done, rd_out, res_out, busy);
        end
        issue(1'b0, 2'b01, 1'b0, 32'h700, 2'd2, 32'd0, 5'd4);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (busy !== 1'b1 || dmem_req !== 1'b1 || dmem_be !== 4'b1100) begin
                failures++; $display("FAIL b2b_busy2 cycle=%0d busy=%b req=%b be=%b required=1/1/1100",
                                     k, busy, dmem_req, dmem_be);
            end
            if (k == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'h8001_7777; end
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || rd_out !== 5'd4 || res_out !== 32'hFFFF_8001) begin
            failures++; $display("FAIL b2b_second done=%b rd=%0d res=%h required=1/4/ffff8001", done, rd_out, res_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 2'b11, 1'b0, 32'h800, 2'd0, 32'hCAFE_0001, 5'd6);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== 71'd0) begin
            failures++; $display("FAIL rst_mid busy=%b req=%b we=%b be=%b addr=%h wdata=%h required=0",
                                 busy, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
        end
        reset_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, busy, mem_err, dmem_req, rd_out, res_out} !== 41'd0) begin
            failures++; $display("FAIL rst_late_ack done=%b busy=%b err=%b req=%b rd=%0d res=%h required=0",
                                 done, busy, mem_err, dmem_req, rd_out, res_out);
        end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; ldsz = 2'b00;
        ld_unsigned = 1'b0; addr = 32'd0; ldshift = 2'd0; st_data = 32'd0;
        rd = 5'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_timeout();
        test_ack_at_limit();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
